// File: rtl/mul_result_fifo.sv
// mul_result_fifo: captures each rising edge of rdy as {s, p} into a first-word-fall-through FIFO read via out_valid/out_ack.
// Optional MUL_RESULT_DROP_OLDEST_EN: when full, a new result overwrites the oldest entry instead of being dropped.
module mul_result_fifo #(
  parameter  int P_WIDTH = 6,
  parameter  int DEPTH   = 4,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [P_WIDTH-1:0] p,
  input  logic               s,
  input  logic               rdy,
  output logic               out_valid,
  output logic [P_WIDTH:0]   out_data,
  input  logic               out_ack,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int AW = $clog2(DEPTH);

`ifdef MUL_RESULT_DROP_OLDEST_EN
  localparam bit LP_DROP_OLDEST = 1'b1;
`else
  localparam bit LP_DROP_OLDEST = 1'b0;
`endif

  logic [P_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rdy_q;
  logic             r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_adv;
  logic w_lost;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = rdy & ~r_rdy_q;
  assign w_pop   = out_ack & ~w_empty;

  // A full FIFO accepts a push only if a pop frees a slot or the oldest entry may be overwritten.
  assign w_wr_en  = w_push & (~w_full | w_pop | LP_DROP_OLDEST);
  assign w_rd_adv = w_pop | (w_push & w_full & LP_DROP_OLDEST);
  assign w_lost   = w_push & w_full & ~w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rdy_q    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_q <= rdy;
      if (w_wr_en)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_rd_adv)      r_count <= r_count + CW'(1);
      else if (!w_wr_en && w_rd_adv) r_count <= r_count - CW'(1);
      if (w_lost)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; count gates its visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {s, p};
  end

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mul_result_fifo.sv
// Self-checking bench for mul_result_fifo: directed table, hand sequences and random traffic against a queue model.
module tb_mul_result_fifo;

  localparam int P_WIDTH = 6;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

`ifdef MUL_RESULT_DROP_OLDEST_EN
  localparam bit DROP_OLDEST = 1'b1;
`else
  localparam bit DROP_OLDEST = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [P_WIDTH-1:0] p;
  logic               s;
  logic               rdy;
  logic               out_valid;
  logic [P_WIDTH:0]   out_data;
  logic               out_ack;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_result_fifo #(.P_WIDTH(P_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .p(p), .s(s), .rdy(rdy),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Reference model: a queue of stored results plus the previous rdy and the sticky flag.
  logic [P_WIDTH:0] mq[$];
  bit               m_rdy_q;
  bit               m_ovf;

  task automatic model_reset();
    mq.delete();
    m_rdy_q = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit sg, input logic [P_WIDTH-1:0] pp,
                            input bit ack, input bit clr);
    bit push, pop, lost;
    push = r && !m_rdy_q;
    pop  = ack && (mq.size() > 0);
    lost = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back({sg, pp});
      else if (DROP_OLDEST) begin
        void'(mq.pop_front());
        mq.push_back({sg, pp});
      end
    end
    if (lost)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_rdy_q = r;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [P_WIDTH:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ".out_data"},  32'(out_data),  32'(head));
    check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  // Drive one cycle's inputs, clock, advance the model, then compare just after the edge.
  task automatic cyc(input bit r, input bit sg, input logic [P_WIDTH-1:0] pp,
                     input bit ack, input bit clr, input string tag);
    rdy = r; s = sg; p = pp; out_ack = ack; clr_ovf = clr;
    @(posedge clk);
    model_edge(r, sg, pp, ack, clr);
    #1;
    compare_model(tag);
  endtask

  task automatic push_val(input bit sg, input logic [P_WIDTH-1:0] pp, input string tag);
    cyc(1'b1, sg, pp, 1'b0, 1'b0, tag);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_expect(input logic [P_WIDTH:0] exp, input string tag);
    check({tag, ".head"}, 32'(out_data), 32'(exp));
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, tag);
  endtask

  typedef struct {
    bit               rdy;
    bit               s;
    logic [P_WIDTH-1:0] p;
    bit               ack;
    bit               exp_valid;
    logic [P_WIDTH:0] exp_data;
    int               exp_count;
  } vec_t;

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 0};
    vecs[1] = '{1'b1, 1'b0, 6'd42, 1'b0, 1'b1, 7'h2A, 1};
    vecs[2] = '{1'b1, 1'b0, 6'd42, 1'b0, 1'b1, 7'h2A, 1};
    vecs[3] = '{1'b1, 1'b0, 6'd42, 1'b0, 1'b1, 7'h2A, 1};
    vecs[4] = '{1'b1, 1'b0, 6'd42, 1'b0, 1'b1, 7'h2A, 1};
    vecs[5] = '{1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 7'h00, 0};

    // Reset with rdy already high: release must not produce a capture.
    rst = 1'b0; rdy = 1'b1; s = 1'b0; p = 6'd9; out_ack = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #1;
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.full",  32'(full), 0);
    #15 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 6'd9, 1'b0, 1'b0, "hold");
      check("hold.count", 32'(count), 0);
      check("hold.data",  32'(out_data), 0);
    end
    cyc(1'b0, 1'b0, 6'd9, 1'b0, 1'b0, "redo");
    cyc(1'b1, 1'b0, 6'd9, 1'b0, 1'b0, "redo");
    check("redo.count", 32'(count), 1);
    check("redo.data",  32'(out_data), 32'h09);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "redo");

    // Single capture, held rdy, pop.
    foreach (vecs[i]) begin
      cyc(vecs[i].rdy, vecs[i].s, vecs[i].p, vecs[i].ack, 1'b0, "vec");
      check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d.count", i), 32'(count),     32'(vecs[i].exp_count));
    end

    // Fill past capacity, last result signed.
    push_val(1'b0, 6'd1, "fill");
    push_val(1'b0, 6'd2, "fill");
    push_val(1'b0, 6'd3, "fill");
    push_val(1'b0, 6'd4, "fill");
    push_val(1'b1, 6'd5, "fill");
    check("fill.full", 32'(full), 1);
    check("fill.ovf",  32'(overflow), 1);
    if (DROP_OLDEST) begin
      pop_expect(7'h02, "pop"); pop_expect(7'h03, "pop");
      pop_expect(7'h04, "pop"); pop_expect(7'h45, "pop");
    end else begin
      pop_expect(7'h01, "pop"); pop_expect(7'h02, "pop");
      pop_expect(7'h03, "pop"); pop_expect(7'h04, "pop");
    end
    check("pop.empty", 32'(empty), 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, "clr");
    check("clr.ovf", 32'(overflow), 0);

    // Push and pop together at full.
    for (int v = 10; v < 14; v++) push_val(1'b0, 6'(v), "pp");
    cyc(1'b1, 1'b0, 6'd14, 1'b1, 1'b0, "pp");
    check("pp.count", 32'(count), 4);
    check("pp.ovf",   32'(overflow), 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, "pp");
    for (int v = 11; v < 15; v++) pop_expect(7'(v), "pp");

    // Wrap-around: three rounds of three.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) push_val(1'b0, 6'(20 + 3 * r + k), "wrap");
      for (int k = 0; k < 3; k++) pop_expect(7'(20 + 3 * r + k), "wrap");
    end
    check("wrap.count", 32'(count), 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "ackempty");
    check("ackempty.count", 32'(count), 0);

    // Empty with push and ack together.
    cyc(1'b1, 1'b0, 6'd7, 1'b1, 1'b0, "pushack");
    check("pushack.count", 32'(count), 1);
    check("pushack.data",  32'(out_data), 32'h07);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "pushack");

    // Overflow set and clear in the same cycle: set wins.
    for (int v = 30; v < 34; v++) push_val(1'b0, 6'(v), "setwin");
    cyc(1'b1, 1'b0, 6'd34, 1'b0, 1'b1, "setwin");
    check("setwin.ovf", 32'(overflow), 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, "setwin");
    check("setwin.clr", 32'(overflow), 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, "setwin");
    check("setwin.count", 32'(count), 3);

    // Asynchronous reset mid-cycle with entries held.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.empty", 32'(empty), 1);
    check("arst.valid", 32'(out_valid), 0);
    check("arst.data",  32'(out_data), 0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
